// File: rtl/codificador_instrucoes.sv
// Instruction encoder and program loader for the unicycle MIPS datapath.
// Packs field bundles into 32-bit words and streams them into instruction memory.
module codificador_instrucoes #(
    parameter int          ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inicio,
    input  logic              fim,
    input  logic              in_valido,
    output logic              in_pronto,
    input  logic [2:0]        classe,
    input  logic [1:0]        sub_op,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [4:0]        shamt,
    input  logic [5:0]        funct,
    input  logic [15:0]       imm,
    input  logic [25:0]       alvo,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_dado,
    output logic              ocupado,
    output logic              concluido,
    output logic              erro,
    output logic              cheio,
    output logic [ADDR_W:0]   contagem
);

    localparam logic [ADDR_W-1:0] BASE = BASE_ADDR[ADDR_W-1:0];

    typedef enum logic [1:0] {
        OCIOSO,
        CARGA,
        ESCRITA,
        CONCLUIDO
    } estado_t;

    estado_t           estado;
    estado_t           estadoProx;
    logic              fimLatch;
    logic [5:0]        opArit;
    logic [31:0]       palavra;
    logic              classeValida;
    logic [ADDR_W-1:0] memAddr;

    always_comb begin
        opArit = 6'b001000;
        unique case (sub_op)
            2'd0: opArit = 6'b001000;
            2'd1: opArit = 6'b001100;
            2'd2: opArit = 6'b001101;
            2'd3: opArit = 6'b001110;
        endcase
    end

    always_comb begin
        palavra      = '0;
        classeValida = 1'b1;
        unique case (classe)
            3'd0:    palavra = {6'b000000, rs, rt, rd, shamt, funct};
            3'd1:    palavra = {opArit, rs, rt, imm};
            3'd2:    palavra = {6'b100011, rs, rt, imm};
            3'd3:    palavra = {6'b101011, rs, rt, imm};
            3'd4:    palavra = {6'b000100, rs, rt, imm};
            3'd5:    palavra = {6'b000010, alvo};
            default: classeValida = 1'b0;
        endcase
    end

    always_comb begin
        estadoProx = estado;
        unique case (estado)
            OCIOSO, CONCLUIDO: begin
                if (inicio) estadoProx = CARGA;
            end
            CARGA: begin
                if (in_valido && classeValida) estadoProx = ESCRITA;
                else if (fim)                  estadoProx = CONCLUIDO;
            end
            ESCRITA: begin
                // a full memory ends the program even without fim
                if (memAddr == '1 || fimLatch || fim) estadoProx = CONCLUIDO;
                else                                  estadoProx = CARGA;
            end
            default: estadoProx = OCIOSO;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) estado <= OCIOSO;
        else       estado <= estadoProx;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            memAddr  <= BASE;
            mem_dado <= '0;
            contagem <= '0;
            erro     <= 1'b0;
            cheio    <= 1'b0;
            fimLatch <= 1'b0;
        end else begin
            unique case (estado)
                OCIOSO, CONCLUIDO: begin
                    if (inicio) begin
                        memAddr  <= BASE;
                        contagem <= '0;
                        erro     <= 1'b0;
                        cheio    <= 1'b0;
                        fimLatch <= 1'b0;
                    end
                end
                CARGA: begin
                    if (in_valido) begin
                        if (classeValida) begin
                            mem_dado <= palavra;
                            fimLatch <= fim;
                        end else begin
                            erro <= 1'b1;
                        end
                    end
                end
                ESCRITA: begin
                    contagem <= contagem + 1'b1;
                    fimLatch <= fimLatch | fim;
                    if (memAddr == '1) cheio   <= 1'b1;
                    else               memAddr <= memAddr + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign mem_addr  = memAddr;
    assign in_pronto = (estado == CARGA);
    assign mem_we    = (estado == ESCRITA);
    assign ocupado   = (estado == CARGA) || (estado == ESCRITA);
    assign concluido = (estado == CONCLUIDO);

endmodule

// File: tb/tb_codificador_instrucoes.sv
// Bench for codificador_instrucoes: scoreboarded random/directed loads on an
// 8-bit instance plus a directed fill test on a 2-bit instance.
module tb_codificador_instrucoes;

    logic        clk = 1'b0;
    logic        reset, inicio, fim, in_valido;
    logic        resetB, inicioB, validoB;
    logic [2:0]  classe;
    logic [1:0]  sub_op;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] alvo;

    logic        in_pronto, mem_we, ocupado, concluido, erro, cheio;
    logic [7:0]  mem_addr;
    logic [31:0] mem_dado;
    logic [8:0]  contagem;

    logic        prontoB, weB, ocupadoB, concluidoB, erroB, cheioB;
    logic [1:0]  addrB;
    logic [31:0] dadoB;
    logic [2:0]  contagemB;

    int total = 0;
    int bad   = 0;

    logic [39:0] esperado[$];
    int mAddr, mCount;
    bit mErro, mCheio;

    always #5 clk = ~clk;

    codificador_instrucoes #(.ADDR_W(8), .BASE_ADDR(0)) dutA (
        .clk(clk), .reset(reset), .inicio(inicio), .fim(fim),
        .in_valido(in_valido), .in_pronto(in_pronto),
        .classe(classe), .sub_op(sub_op), .rs(rs), .rt(rt), .rd(rd),
        .shamt(shamt), .funct(funct), .imm(imm), .alvo(alvo),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_dado(mem_dado),
        .ocupado(ocupado), .concluido(concluido), .erro(erro),
        .cheio(cheio), .contagem(contagem)
    );

    codificador_instrucoes #(.ADDR_W(2), .BASE_ADDR(2)) dutB (
        .clk(clk), .reset(resetB), .inicio(inicioB), .fim(1'b0),
        .in_valido(validoB), .in_pronto(prontoB),
        .classe(classe), .sub_op(sub_op), .rs(rs), .rt(rt), .rd(rd),
        .shamt(shamt), .funct(funct), .imm(imm), .alvo(alvo),
        .mem_we(weB), .mem_addr(addrB), .mem_dado(dadoB),
        .ocupado(ocupadoB), .concluido(concluidoB), .erro(erroB),
        .cheio(cheioB), .contagem(contagemB)
    );

    task automatic chk(input string nome, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     nome, act, exp, $time);
        end
    endtask

    // reference encoder: opcode and fields placed by weighted sums
    function automatic logic [31:0] encode(
        input logic [2:0] c, input logic [1:0] s,
        input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
        input logic [4:0] sh, input logic [5:0] fn,
        input logic [15:0] im, input logic [25:0] al);
        longint unsigned opTab[6] = '{0, 8, 35, 43, 4, 2};
        longint unsigned aritTab[4] = '{8, 12, 13, 14};
        longint unsigned op, w;
        op = (c == 3'd1) ? aritTab[s] : opTab[c];
        if (c == 3'd5)
            w = op * 64'd67108864 + 64'(al);
        else if (c == 3'd0)
            w = 64'(a) * 64'd2097152 + 64'(b) * 64'd65536 +
                64'(d) * 64'd2048 + 64'(sh) * 64'd64 + 64'(fn);
        else
            w = op * 64'd67108864 + 64'(a) * 64'd2097152 +
                64'(b) * 64'd65536 + 64'(im);
        return 32'(w);
    endfunction

    function automatic logic [31:0] encodeNow();
        return encode(classe, sub_op, rs, rt, rd, shamt, funct, imm, alvo);
    endfunction

    logic weAnterior = 1'b0;
    always @(negedge clk) begin
        if (mem_we) begin
            chk("we_single_cycle", 32'(weAnterior), 32'd0);
            if (esperado.size() == 0) begin
                chk("unexpected_write", 32'd1, 32'd0);
            end else begin
                logic [39:0] e;
                e = esperado.pop_front();
                chk("write_addr", 32'(mem_addr), 32'(e[39:32]));
                chk("write_data", mem_dado, e[31:0]);
            end
        end
        weAnterior = mem_we;
    end

    task automatic setFields(input logic [2:0] c, input logic [1:0] s,
                             input logic [4:0] a, input logic [4:0] b,
                             input logic [4:0] d, input logic [4:0] sh,
                             input logic [5:0] fn, input logic [15:0] im,
                             input logic [25:0] al);
        classe = c; sub_op = s; rs = a; rt = b; rd = d;
        shamt = sh; funct = fn; imm = im; alvo = al;
    endtask

    task automatic randFields(input logic [2:0] c);
        setFields(c, 2'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                  5'($urandom), 6'($urandom), 16'($urandom), 26'($urandom));
    endtask

    // fields already set; called right after a posedge
    task automatic send(input bit comFim, input bit manter);
        int n = 0;
        in_valido = 1'b1;
        fim = comFim;
        @(negedge clk);
        while (!in_pronto && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("pronto_wait", 32'(in_pronto), 32'd1);
        if (classe <= 3'd5) begin
            esperado.push_back({8'(mAddr), encodeNow()});
            mCount++;
            if (mAddr == 255) mCheio = 1'b1;
            else              mAddr++;
        end else begin
            mErro = 1'b1;
        end
        @(posedge clk);
        #1;
        if (!manter) in_valido = 1'b0;
        fim = 1'b0;
    endtask

    task automatic start();
        inicio = 1'b1;
        @(posedge clk);
        #1;
        inicio = 1'b0;
        mAddr = 0; mCount = 0; mErro = 1'b0; mCheio = 1'b0;
        @(negedge clk);
        chk("start_ocupado", 32'(ocupado), 32'd1);
        chk("start_addr", 32'(mem_addr), 32'd0);
        chk("start_contagem", 32'(contagem), 32'd0);
        chk("start_erro", 32'(erro), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic checkResetA();
        chk("rst_pronto", 32'(in_pronto), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_dado", mem_dado, 32'd0);
        chk("rst_ocupado", 32'(ocupado), 32'd0);
        chk("rst_concluido", 32'(concluido), 32'd0);
        chk("rst_erro", 32'(erro), 32'd0);
        chk("rst_cheio", 32'(cheio), 32'd0);
        chk("rst_contagem", 32'(contagem), 32'd0);
    endtask

    task automatic sendB(input logic [31:0] addrEsp);
        int n = 0;
        logic [31:0] palavraEsp;
        randFields(3'($urandom_range(0, 5)));
        palavraEsp = encodeNow();
        validoB = 1'b1;
        @(negedge clk);
        while (!prontoB && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("B_pronto_wait", 32'(prontoB), 32'd1);
        @(posedge clk);
        #1;
        validoB = 1'b0;
        @(negedge clk);
        chk("B_we", 32'(weB), 32'd1);
        chk("B_addr", 32'(addrB), addrEsp);
        chk("B_dado", dadoB, palavraEsp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; resetB = 1'b1;
        inicio = 1'b0; inicioB = 1'b0; fim = 1'b0;
        in_valido = 1'b0; validoB = 1'b0;
        randFields(3'd0);
        mAddr = 0; mCount = 0; mErro = 1'b0; mCheio = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0; resetB = 1'b0;
        @(negedge clk);
        checkResetA();
        @(posedge clk);
        #1;

        start();
        setFields(3'd1, 2'd0, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'd5, 26'd0);
        send(1'b0, 1'b0);
        @(negedge clk);
        chk("addi_we", 32'(mem_we), 32'd1);
        chk("addi_addr", 32'(mem_addr), 32'd0);
        chk("addi_dado", mem_dado, 32'h20080005);
        @(negedge clk);
        chk("addi_contagem", 32'(contagem), 32'd1);
        chk("addi_addr_after", 32'(mem_addr), 32'd1);
        @(posedge clk);
        #1;

        setFields(3'd0, 2'd0, 5'd8, 5'd9, 5'd10, 5'd0, 6'h20, 16'd0, 26'd0);
        send(1'b0, 1'b1);
        setFields(3'd2, 2'd0, 5'd8, 5'd9, 5'd0, 5'd0, 6'd0, 16'd4, 26'd0);
        send(1'b0, 1'b1);
        setFields(3'd3, 2'd0, 5'd8, 5'd9, 5'd0, 5'd0, 6'd0, 16'd8, 26'd0);
        send(1'b0, 1'b1);
        setFields(3'd4, 2'd0, 5'd8, 5'd9, 5'd0, 5'd0, 6'd0, 16'hFFFF, 26'd0);
        send(1'b0, 1'b1);
        setFields(3'd5, 2'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h10);
        send(1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk("b2b_contagem", 32'(contagem), 32'(mCount));
        chk("b2b_addr", 32'(mem_addr), 32'(mAddr));
        @(posedge clk);
        #1;

        randFields(3'd6);
        send(1'b0, 1'b0);
        @(negedge clk);
        chk("inv_no_we", 32'(mem_we), 32'd0);
        chk("inv_erro", 32'(erro), 32'd1);
        chk("inv_addr", 32'(mem_addr), 32'(mAddr));
        @(posedge clk);
        #1;
        randFields(3'd2);
        send(1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk("inv_erro_sticky", 32'(erro), 32'd1);
        chk("inv_contagem", 32'(contagem), 32'(mCount));
        @(posedge clk);
        #1;

        randFields(3'd4);
        send(1'b1, 1'b0);
        @(negedge clk);
        chk("fimhs_we", 32'(mem_we), 32'd1);
        @(negedge clk);
        chk("fimhs_concluido", 32'(concluido), 32'd1);
        chk("fimhs_ocupado", 32'(ocupado), 32'd0);
        chk("fimhs_contagem", 32'(contagem), 32'(mCount));
        in_valido = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("fimhs_pronto_low", 32'(in_pronto), 32'd0);
        end
        in_valido = 1'b0;
        @(posedge clk);
        #1;

        start();
        for (int i = 0; i < 50; i++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            randFields(3'($urandom_range(0, 7)));
            send(1'b0, 1'b0);
        end
        randFields(3'($urandom_range(0, 5)));
        send(1'b0, 1'b0);
        fim = 1'b1;
        @(posedge clk);
        #1;
        fim = 1'b0;
        @(negedge clk);
        chk("rnd_concluido", 32'(concluido), 32'd1);
        chk("rnd_contagem", 32'(contagem), 32'(mCount));
        chk("rnd_erro", 32'(erro), 32'(mErro));
        chk("rnd_addr", 32'(mem_addr), 32'(mAddr));
        chk("rnd_cheio", 32'(cheio), 32'(mCheio));
        @(posedge clk);
        #1;

        start();
        fim = 1'b1;
        @(posedge clk);
        #1;
        fim = 1'b0;
        @(negedge clk);
        chk("barefim_concluido", 32'(concluido), 32'd1);
        chk("barefim_contagem", 32'(contagem), 32'd0);
        @(posedge clk);
        #1;

        start();
        randFields(3'd0);
        send(1'b0, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        mAddr = 0; mCount = 0; mErro = 1'b0; mCheio = 1'b0;
        @(negedge clk);
        checkResetA();
        @(negedge clk);
        chk("rst_stays_idle", 32'(in_pronto), 32'd0);
        @(posedge clk);
        #1;

        inicioB = 1'b1;
        @(posedge clk);
        #1;
        inicioB = 1'b0;
        sendB(32'd2);
        sendB(32'd3);
        @(negedge clk);
        chk("B_cheio", 32'(cheioB), 32'd1);
        chk("B_concluido", 32'(concluidoB), 32'd1);
        chk("B_addr_hold", 32'(addrB), 32'd3);
        chk("B_contagem", 32'(contagemB), 32'd2);
        @(posedge clk);
        #1;
        inicioB = 1'b1;
        @(posedge clk);
        #1;
        inicioB = 1'b0;
        @(negedge clk);
        chk("B_restart_cheio", 32'(cheioB), 32'd0);
        chk("B_restart_addr", 32'(addrB), 32'd2);
        chk("B_restart_ocupado", 32'(ocupadoB), 32'd1);
        chk("B_restart_contagem", 32'(contagemB), 32'd0);

        repeat (2) @(negedge clk);
        chk("scoreboard_empty", 32'(esperado.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
